// File: rtl/tl_ns_reg_pkg.sv
// Shared constants for the traffic-light controller: state codes and light codes.
// Imported by the next-state/register block, the dwell timer, and the output decoder.
package tl_ns_reg_pkg;

  // State codes carried on q; the top bit selects street A (0) or B (1).
  localparam logic [2:0] S0 = 3'b000;  // A green
  localparam logic [2:0] S1 = 3'b001;  // A yellow
  localparam logic [2:0] S2 = 3'b010;  // A left
  localparam logic [2:0] S3 = 3'b011;  // A yellow after left
  localparam logic [2:0] S4 = 3'b100;  // B green
  localparam logic [2:0] S5 = 3'b101;  // B yellow
  localparam logic [2:0] S6 = 3'b110;  // B left
  localparam logic [2:0] S7 = 3'b111;  // B yellow after left

  // Light codes decoded downstream from q.
  typedef enum logic [1:0] {
    LIGHT_GREEN  = 2'b00,
    LIGHT_YELLOW = 2'b01,
    LIGHT_LEFT   = 2'b10,
    LIGHT_RED    = 2'b11
  } light_t;

  // True for the two left-turn phases.
  function automatic logic is_left(input logic [2:0] s);
    return (s == S2) || (s == S6);
  endfunction

endpackage

// File: rtl/tl_timer.sv
// Dwell timer: counts cycles spent in the current state, saturating at all-ones.
// Cleared synchronously by reset or by clr (asserted on the edge where q changes).
module tl_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tl_ns_reg.sv
// Next-state logic, state register and left-turn request latches for the
// traffic-light controller; q feeds the downstream light decoder.
module tl_ns_reg
  import tl_ns_reg_pkg::*;
#(
  parameter int GREEN_MIN  = 4,
  parameter int YELLOW_CYC = 2,
  parameter int LEFT_CYC   = 3,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       Lta,
  input  logic       Ltb,
  output logic [2:0] q,
  output logic       lreq_a,
  output logic       lreq_b
);

  // Terminal counts: the timer reads N-1 during the last cycle of an N-cycle dwell.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] LEFT_LAST   = CNT_W'(LEFT_CYC - 1);

  logic [2:0]       q_next;
  logic [CNT_W-1:0] tmr;
  logic             tmr_clr;
  logic             green_done;
  logic             yellow_done;
  logic             left_done;
  logic             enter_s2;
  logic             enter_s6;

  assign green_done  = (tmr >= GREEN_LAST);
  assign yellow_done = (tmr == YELLOW_LAST);
  assign left_done   = (tmr == LEFT_LAST);

  // A request arriving in the same cycle as the yellow exit is still honoured.
  always_comb begin
    q_next = q;
    case (q)
      S0: if (green_done && !Ta) q_next = S1;
      S1: if (yellow_done)       q_next = (lreq_a || Lta) ? S2 : S4;
      S2: if (left_done)         q_next = S3;
      S3: if (yellow_done)       q_next = S4;
      S4: if (green_done && !Tb) q_next = S5;
      S5: if (yellow_done)       q_next = (lreq_b || Ltb) ? S6 : S0;
      S6: if (left_done)         q_next = S7;
      S7: if (yellow_done)       q_next = S0;
      default:                   q_next = S0;
    endcase
  end

  assign tmr_clr  = (q_next != q);
  assign enter_s2 = (q_next == S2) && (q != S2);
  assign enter_s6 = (q_next == S6) && (q != S6);

  tl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .cnt   (tmr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= S0;
    end else begin
      q <= q_next;
    end
  end

  // Entering the left phase consumes the request; requests during it are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      lreq_a <= 1'b0;
      lreq_b <= 1'b0;
    end else begin
      if (enter_s2) begin
        lreq_a <= 1'b0;
      end else if (Lta && !is_left(q) || Lta && q == S6) begin
        lreq_a <= 1'b1;
      end
      if (enter_s6) begin
        lreq_b <= 1'b0;
      end else if (Ltb && q != S6) begin
        lreq_b <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tl_ns_reg.sv
// Directed bench for tl_ns_reg with default parameters: reset, green hold,
// plain cycle, A and B left phases, and reset in the middle of a left phase.
module tb_tl_ns_reg;

  logic       clk;
  logic       reset;
  logic       Ta;
  logic       Tb;
  logic       Lta;
  logic       Ltb;
  logic [2:0] q;
  logic       lreq_a;
  logic       lreq_b;

  int total = 0;
  int bad   = 0;

  logic [2:0] exp_q[$];

  tl_ns_reg dut (
    .clk    (clk),
    .reset  (reset),
    .Ta     (Ta),
    .Tb     (Tb),
    .Lta    (Lta),
    .Ltb    (Ltb),
    .q      (q),
    .lreq_a (lreq_a),
    .lreq_b (lreq_b)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge, then settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: one edge per queued expected state code.
  task automatic drain(input string tag);
    logic [2:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step();
      chk(tag, {5'd0, q}, {5'd0, e});
    end
  endtask

  initial begin
    reset = 1'b1; Ta = 1'b1; Tb = 1'b0; Lta = 1'b1; Ltb = 1'b0;

    // Reset with Ta and Lta active.
    step();
    chk("rst_q", {5'd0, q}, 8'h00);
    chk("rst_lreq_a", {7'd0, lreq_a}, 8'h00);
    chk("rst_lreq_b", {7'd0, lreq_b}, 8'h00);
    chk("rst_tmr", 8'(dut.tmr), 8'h00);
    step();
    chk("rst2_lreq_a", {7'd0, lreq_a}, 8'h00);
    reset = 1'b0; Lta = 1'b0;

    // Ta held: stay in S0 for 10 cycles, then leave one cycle after Ta falls.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_s0", {5'd0, q}, 8'h00);
    end
    chk("tmr_counting", 8'(dut.tmr), 8'd10);
    Ta = 1'b0;
    step();
    chk("s0_exit", {5'd0, q}, 8'h01);
    exp_q = '{3'b001, 3'b100};
    drain("s1_to_s4");

    // Plain cycle, no left requests.
    exp_q = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b101,
              3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    drain("plain_cycle");

    // Run to S0, then pulse Lta for one cycle.
    exp_q = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b000};
    drain("to_s0");
    Lta = 1'b1;
    step();
    chk("lta_latch", {7'd0, lreq_a}, 8'h01);
    chk("lta_q", {5'd0, q}, 8'h00);
    Lta = 1'b0;
    exp_q = '{3'b000, 3'b000, 3'b001, 3'b001};
    drain("a_pre_left");
    chk("lreq_a_held_s1", {7'd0, lreq_a}, 8'h01);
    exp_q = '{3'b010};
    drain("a_left_entry");
    chk("lreq_a_clr", {7'd0, lreq_a}, 8'h00);
    exp_q = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b100};
    drain("a_left_seq");

    // Ltb raised only in the final S5 cycle, then held through S6.
    exp_q = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b101};
    drain("to_s5_last");
    chk("lreq_b_idle", {7'd0, lreq_b}, 8'h00);
    Ltb = 1'b1;
    step();
    chk("b_left_same_cycle", {5'd0, q}, 8'h06);
    chk("lreq_b_clr_wins", {7'd0, lreq_b}, 8'h00);
    exp_q = '{3'b110, 3'b110, 3'b111};
    drain("b_left_seq");
    chk("lreq_b_ignored_s6", {7'd0, lreq_b}, 8'h00);
    Ltb = 1'b0;
    exp_q = '{3'b111, 3'b000};
    drain("b_to_s0");

    // Latch both requests, reach S6, then reset at tmr=1.
    Ltb = 1'b1; Lta = 1'b1;
    step();
    Ltb = 1'b0; Lta = 1'b0;
    chk("both_latched", {6'd0, lreq_a, lreq_b}, 8'h03);
    exp_q = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
    drain("to_a_left");
    chk("lreq_b_kept", {7'd0, lreq_b}, 8'h01);
    Lta = 1'b1;
    exp_q = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b100};
    drain("a_left_again");
    Lta = 1'b0;
    chk("lta_ignored_in_s2", {7'd0, lreq_a}, 8'h01);
    exp_q = '{3'b100, 3'b100, 3'b100, 3'b101, 3'b101, 3'b110, 3'b110};
    drain("to_s6");
    chk("s6_tmr1", 8'(dut.tmr), 8'h01);
    reset = 1'b1; Ta = 1'b1; Tb = 1'b1;
    step();
    chk("mid_rst_q", {5'd0, q}, 8'h00);
    chk("mid_rst_tmr", 8'(dut.tmr), 8'h00);
    chk("mid_rst_latches", {6'd0, lreq_a, lreq_b}, 8'h00);
    reset = 1'b0; Ta = 1'b0; Tb = 1'b0;
    exp_q = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b100};
    drain("post_rst_green");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
